// File: rtl/geofence_driver.sv
// Point-stream transmitter for the geofence core: buffers objects of 7 points, streams them
// on X/Y and collects is_inside. Define GEOFENCE_DRV_TIMEOUT_EN to enable the wait timeout.
module geofence_driver #(
    parameter int unsigned MAX_OBJ = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ld_en,
    input  logic [9:0]                   ld_x,
    input  logic [9:0]                   ld_y,
    input  logic                         ld_clr,
    input  logic                         start,
    output logic [9:0]                   X,
    output logic [9:0]                   Y,
    input  logic                         valid,
    input  logic                         is_inside,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(MAX_OBJ+1)-1:0] obj_cnt,
    output logic [$clog2(MAX_OBJ+1)-1:0] inside_cnt,
    output logic [MAX_OBJ-1:0]           result,
    output logic                         timeout_err
);

    localparam int unsigned DEPTH = MAX_OBJ * 7;
    localparam int unsigned AW    = $clog2(DEPTH + 1);
    localparam int unsigned CW    = $clog2(MAX_OBJ + 1);
    localparam int unsigned OW    = (MAX_OBJ > 1) ? $clog2(MAX_OBJ) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSend = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [19:0]        pt_mem [DEPTH];
    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      wp_q, wp_d;
    logic [OW-1:0]      obj_q, obj_d;
    logic [2:0]         p_q, p_d;
    logic [9:0]         x_q, x_d, y_q, y_d;
    logic [MAX_OBJ-1:0] result_q, result_d;
    logic [CW-1:0]      inside_q, inside_d;
    logic [AW-1:0]      rd_addr;
    logic [19:0]        rd_data;
    logic               wr_en;
    logic               capture;
    logic               last_obj;

`ifdef GEOFENCE_DRV_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_q, wait_d;
    logic          terr_q, terr_d;
    logic          timed_out;
`endif

    assign obj_cnt    = CW'(wp_q / AW'(7));
    assign wr_en      = reset && (state_q == StIdle) && ld_en && !ld_clr && (wp_q != AW'(DEPTH));
    assign rd_data    = pt_mem[rd_addr];
    assign last_obj   = (CW'(obj_q) == obj_cnt - CW'(1));
    assign X          = x_q;
    assign Y          = y_q;
    assign busy       = (state_q == StSend) || (state_q == StWait);
    assign done       = (state_q == StDone);
    assign result     = result_q;
    assign inside_cnt = inside_q;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Point buffer is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pt_mem[wp_q] <= {ld_x, ld_y};
        end
    end

    always_comb begin
        wp_d = wp_q;
        if (state_q == StIdle) begin
            if (ld_clr) begin
                wp_d = '0;
            end else if (wr_en) begin
                wp_d = wp_q + AW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        obj_d    = obj_q;
        p_d      = p_q;
        x_d      = x_q;
        y_d      = y_q;
        result_d = result_q;
        inside_d = inside_q;
        rd_addr  = '0;
        capture  = valid;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
        wait_d    = wait_q;
        terr_d    = terr_q;
        timed_out = (state_q == StWait) && !valid && (wait_q == TW'(TIMEOUT - 1));
        capture   = valid || timed_out;
`endif
        case (state_q)
            StIdle: begin
                x_d = '0;
                y_d = '0;
                if (start) begin
                    result_d = '0;
                    inside_d = '0;
                    obj_d    = '0;
                    p_d      = '0;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                    terr_d   = 1'b0;
`endif
                    if (obj_cnt == '0) begin
                        state_d = StDone;
                    end else begin
                        // Target goes out on the start edge so it is visible the next cycle.
                        {x_d, y_d} = rd_data;
                        p_d        = 3'd1;
                        state_d    = StSend;
                    end
                end
            end
            StSend: begin
                rd_addr    = AW'(obj_q) * AW'(7) + AW'(p_q);
                {x_d, y_d} = rd_data;
                if (p_q == 3'd6) begin
                    state_d = StWait;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    p_d = p_q + 3'd1;
                end
            end
            StWait: begin
                if (capture) begin
                    result_d[obj_q] = valid & is_inside;
                    inside_d        = inside_q + CW'(valid & is_inside);
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                    if (timed_out) begin
                        terr_d = 1'b1;
                    end
`endif
                    if (last_obj) begin
                        x_d     = '0;
                        y_d     = '0;
                        state_d = StDone;
                    end else begin
                        rd_addr    = AW'(obj_q) * AW'(7) + AW'(7);
                        {x_d, y_d} = rd_data;
                        obj_d      = obj_q + OW'(1);
                        p_d        = 3'd1;
                        state_d    = StSend;
                    end
                end else begin
`ifdef GEOFENCE_DRV_TIMEOUT_EN
                    wait_d = wait_q + TW'(1);
`endif
                end
            end
            StDone: begin
                x_d     = '0;
                y_d     = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            wp_q     <= '0;
            obj_q    <= '0;
            p_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result_q <= '0;
            inside_q <= '0;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
            wait_q   <= '0;
            terr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            obj_q    <= obj_d;
            p_q      <= p_d;
            x_q      <= x_d;
            y_q      <= y_d;
            result_q <= result_d;
            inside_q <= inside_d;
`ifdef GEOFENCE_DRV_TIMEOUT_EN
            wait_q   <= wait_d;
            terr_q   <= terr_d;
`endif
        end
    end

endmodule

// File: doc/geofence_driver.md
Name: geofence_driver

Overview:
- Transmitter side of the geofence point-stream interface.
- Buffers up to MAX_OBJ objects; each object is 7 points: the target point followed by 6 fence vertices.
- On start, streams each object onto X/Y, one point per cycle, then waits for valid from the geofence receiver and captures is_inside.
- Used as the on-chip stimulus and collection engine in front of the geofence core, in both the self-test top and the FPGA bring-up top.

Parameters:
- MAX_OBJ, 16, number of objects the point buffer holds (buffer depth = MAX_OBJ*7 entries of 20 bits).
- TIMEOUT, 255, cycles to wait for valid before abandoning an object (used only with TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- ld_en  input  1  write one point into the buffer this cycle.
- ld_x  input  10  X coordinate of the point being loaded.
- ld_y  input  10  Y coordinate of the point being loaded.
- ld_clr  input  1  clear the write pointer (empties the buffer).
- start  input  1  begin streaming all complete buffered objects.
- X  output  10  point X to the geofence.
- Y  output  10  point Y to the geofence.
- valid  input  1  result strobe from the geofence.
- is_inside  input  1  result from the geofence, qualified by valid.
- busy  output  1  high in SEND or WAIT.
- done  output  1  one-cycle pulse when the last object's result is captured.
- obj_cnt  output  $clog2(MAX_OBJ+1)  number of complete objects in the buffer (wp/7).
- inside_cnt  output  $clog2(MAX_OBJ+1)  number of objects reported inside.
- result  output  MAX_OBJ  bit i = is_inside captured for object i.
- timeout_err  output  1  sticky; set if any object timed out.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State = IDLE; write pointer wp = 0.
  - X, Y, busy, done, inside_cnt, result, timeout_err all 0.
  - Buffer contents are not reset.
- Loading (IDLE only):
  - ld_en writes {ld_x, ld_y} to buf[wp], then wp++.
  - ld_en is ignored when wp == MAX_OBJ*7, or when not in IDLE.
  - ld_clr sets wp = 0 and takes priority over ld_en in the same cycle.
  - obj_cnt = floor(wp/7). A trailing partial object is never sent.
- State machine: IDLE -> SEND -> WAIT -> (SEND | DONE) -> IDLE.
- IDLE:
  - start==1 clears result, inside_cnt and timeout_err, sets obj = 0, p = 0.
  - If obj_cnt == 0, go to DONE; otherwise go to SEND.
  - start in any other state is ignored. X/Y are driven 0 in IDLE.
- SEND:
  - X/Y are registered: X/Y <= buf[obj*7+p] each cycle, with p = 0..6.
  - Start latency: start sampled at edge k puts the target point (p = 0) on X/Y during cycle k+1. The 6 vertices follow on consecutive cycles with no gaps.
  - After p == 6 is loaded, go to WAIT.
  - valid during SEND is ignored.
- WAIT:
  - X/Y hold the 6th vertex.
  - On a cycle with valid==1: result[obj] <= is_inside; inside_cnt += is_inside.
  - If obj == obj_cnt-1, go to DONE; otherwise obj++, p = 0, go to SEND. The next object's target appears on X/Y the cycle after valid.
- DONE: done = 1 for exactly one cycle, then go to IDLE. result, inside_cnt and timeout_err hold until the next accepted start.
- busy = 1 exactly in SEND and WAIT. done and busy are never high together.
- Reset mid-stream: the machine returns to IDLE immediately and all outputs clear. wp is also cleared, so the host must reload.
- Counter widths: inside_cnt never exceeds obj_cnt. The buffer address obj*7+p is computed at full width, with no wrap.

Optional Feature:
- Macro: GEOFENCE_DRV_TIMEOUT_EN.
- Defined: an 8-bit (or wider, to fit TIMEOUT) wait counter clears on entry to WAIT and increments each WAIT cycle without valid.
  - When it reaches TIMEOUT, the current object is treated as valid with is_inside = 0: result[obj] = 0, inside_cnt unchanged, and timeout_err is set (sticky).
  - Flow then continues exactly as on valid.
  - valid arriving in the same cycle as the timeout wins: it is captured normally and no error is flagged.
- Not defined: WAIT lasts indefinitely until valid; timeout_err is tied 0; no counter is synthesized.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> X=Y=0, busy=0, done=0, result=0, obj_cnt=0.
- Single object: load target (300,300) plus a hexagon around it, start. Expected:
  - X/Y show the 7 points on 7 consecutive cycles, starting the cycle after start, then hold the last vertex.
  - Model valid=1, is_inside=1 five cycles later -> result[0]=1, inside_cnt=1, done pulses one cycle later.
- Three objects with model results 1,0,1 -> result=3'b101, inside_cnt=2, done exactly once; each new target is driven the cycle after its preceding valid.
- Boundaries:
  - Load 16*7 points plus 3 extra -> wp saturates at 112, obj_cnt=16.
  - Load 10 points only -> obj_cnt=1 and only 7 points are streamed.
  - start with wp=0 -> done on the next cycle, result=0.
- Mid-stream reset: assert reset=0 during the 4th SEND cycle of object 1 -> next cycle state IDLE, busy=0, X=Y=0, result=0, obj_cnt=0. A start after reload restarts from object 0.
- Timeout (GEOFENCE_DRV_TIMEOUT_EN, TIMEOUT=20): no valid for object 0 -> after 20 WAIT cycles result[0]=0, timeout_err=1, object 1 streams. Same run without the macro -> busy stays 1 indefinitely.
